riscv_mem_load_store_unit: RTL and testbench

MEM-stage load/store unit that consumes the EX-stage ALU result: the effective address, the rs2 store data, the access width/sign and the read/write flags. It turns each access into one AXI4-Lite master transaction on a 64-bit data bus. For loads it aligns and extends the returned lane. The pipeline is stalled while a transaction is outstanding.

---
 rtl/riscv_mem_load_store_unit.sv | 188 ++++++++++++++++++
 tb/tb_riscv_mem_load_store_unit.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_mem_load_store_unit.sv
// MEM-stage load/store unit: one AXI4-Lite transaction per load or store, with load lane
// alignment and extension. The pipeline is stalled while the access is outstanding.
module riscv_mem_load_store_unit #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_read,
    input  logic                    i_write,
    input  logic [2:0]              i_width,
    input  logic [DATA_WIDTH-1:0]   i_addr,
    input  logic [DATA_WIDTH-1:0]   i_wr_data,
    output logic                    o_stall,
    output logic                    o_done,
    output logic [DATA_WIDTH-1:0]   o_rd_data,
    output logic                    o_misaligned,
    output logic                    o_bus_err,
    output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
    output logic [2:0]              m_axi_awprot,
    output logic                    m_axi_awvalid,
    input  logic                    m_axi_awready,
    output logic [DATA_WIDTH-1:0]   m_axi_wdata,
    output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
    output logic                    m_axi_wvalid,
    input  logic                    m_axi_wready,
    input  logic [1:0]              m_axi_bresp,
    input  logic                    m_axi_bvalid,
    output logic                    m_axi_bready,
    output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
    output logic [2:0]              m_axi_arprot,
    output logic                    m_axi_arvalid,
    input  logic                    m_axi_arready,
    input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
    input  logic [1:0]              m_axi_rresp,
    input  logic                    m_axi_rvalid,
    output logic                    m_axi_rready
);
    localparam logic [2:0] StIdle = 3'd0;
    localparam logic [2:0] StWr   = 3'd1;
    localparam logic [2:0] StWb   = 3'd2;
    localparam logic [2:0] StRa   = 3'd3;
    localparam logic [2:0] StRd   = 3'd4;
    localparam logic [2:0] StResp = 3'd5;

    logic [2:0]              state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [2:0]              width_q, width_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [DATA_WIDTH/8-1:0] wstrb_q, wstrb_d;
    logic [DATA_WIDTH-1:0]   rd_data_q, rd_data_d;
    logic                    aw_done_q, aw_done_d;
    logic                    w_done_q, w_done_d;
    logic                    err_q, err_d;
    logic                    mis_q, mis_d;

    logic                    req;
    logic                    misaligned;
    logic [7:0]              size_mask;
    logic [DATA_WIDTH-1:0]   lane;
    logic [DATA_WIDTH-1:0]   load_data;
    logic                    sext;
    logic                    unused_addr_hi;

    assign req            = i_read | i_write;
    assign unused_addr_hi = ^i_addr[DATA_WIDTH-1:ADDR_WIDTH];

    always_comb begin
        unique case (i_width[1:0])
            2'd0: begin misaligned = 1'b0;          size_mask = 8'h01; end
            2'd1: begin misaligned = i_addr[0];     size_mask = 8'h03; end
            2'd2: begin misaligned = |i_addr[1:0];  size_mask = 8'h0F; end
            default: begin misaligned = |i_addr[2:0]; size_mask = 8'hFF; end
        endcase
    end

    // Returned data is lane-aligned, so shift the addressed bytes down to bit 0.
    assign lane = m_axi_rdata >> {addr_q[2:0], 3'b000};
    assign sext = width_q[2];

    always_comb begin
        unique case (width_q[1:0])
            2'd0: load_data = {{(DATA_WIDTH-8){sext & lane[7]}}, lane[7:0]};
            2'd1: load_data = {{(DATA_WIDTH-16){sext & lane[15]}}, lane[15:0]};
            2'd2: load_data = {{(DATA_WIDTH-32){sext & lane[31]}}, lane[31:0]};
            default: load_data = lane;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        width_d   = width_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        rd_data_d = rd_data_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        err_d     = err_q;
        mis_d     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (req) begin
                    if (misaligned) begin
                        mis_d = 1'b1;
                    end else begin
                        addr_d    = i_addr[ADDR_WIDTH-1:0];
                        width_d   = i_width;
                        wdata_d   = i_wr_data << {i_addr[2:0], 3'b000};
                        wstrb_d   = size_mask << i_addr[2:0];
                        aw_done_d = 1'b0;
                        w_done_d  = 1'b0;
                        err_d     = 1'b0;
                        state_d   = i_write ? StWr : StRa;
                    end
                end
            end
            StWr: begin
                if (m_axi_awvalid && m_axi_awready) aw_done_d = 1'b1;
                if (m_axi_wvalid && m_axi_wready)   w_done_d  = 1'b1;
                if (aw_done_d && w_done_d) state_d = StWb;
            end
            StWb: begin
                if (m_axi_bvalid) begin
                    err_d   = (m_axi_bresp != 2'b00);
                    state_d = StResp;
                end
            end
            StRa: begin
                if (m_axi_arready) state_d = StRd;
            end
            StRd: begin
                if (m_axi_rvalid) begin
                    rd_data_d = load_data;
                    err_d     = (m_axi_rresp != 2'b00);
                    state_d   = StResp;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= StIdle;
            addr_q    <= '0;
            width_q   <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            rd_data_q <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            err_q     <= 1'b0;
            mis_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            width_q   <= width_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            rd_data_q <= rd_data_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            err_q     <= err_d;
            mis_q     <= mis_d;
        end
    end

    // Stall drops in RESP so the pipeline advances exactly once per access.
    assign o_stall      = ((state_q != StIdle) && (state_q != StResp)) ||
                          ((state_q == StIdle) && req);
    assign o_done       = (state_q == StResp);
    assign o_bus_err    = (state_q == StResp) && err_q;
    assign o_misaligned = mis_q;
    assign o_rd_data    = rd_data_q;

    assign m_axi_awaddr  = addr_q;
    assign m_axi_awprot  = 3'b000;
    assign m_axi_awvalid = (state_q == StWr) && !aw_done_q;
    assign m_axi_wdata   = wdata_q;
    assign m_axi_wstrb   = wstrb_q;
    assign m_axi_wvalid  = (state_q == StWr) && !w_done_q;
    assign m_axi_bready  = (state_q == StWb);
    assign m_axi_araddr  = addr_q;
    assign m_axi_arprot  = 3'b000;
    assign m_axi_arvalid = (state_q == StRa);
    assign m_axi_rready  = (state_q == StRd);
endmodule

// File: tb/tb_riscv_mem_load_store_unit.sv
// Directed and randomized checks of the load/store unit against a byte-level reference
// model, with a delay-programmable AXI4-Lite slave driven from the same process.
module tb_riscv_mem_load_store_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic        i_read, i_write;
    logic [2:0]  i_width;
    logic [63:0] i_addr, i_wr_data;
    logic        o_stall, o_done, o_misaligned, o_bus_err;
    logic [63:0] o_rd_data;
    logic [31:0] awaddr, araddr;
    logic [2:0]  awprot, arprot;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [63:0] wdata, rdata;
    logic [7:0]  wstrb;
    logic [1:0]  bresp, rresp;

    int          checks = 0;
    int          failures = 0;
    logic [63:0] last_rd = '0;

    always #5 clk = ~clk;

    riscv_mem_load_store_unit dut (
        .i_clk(clk), .i_rst(rst), .i_read(i_read), .i_write(i_write), .i_width(i_width),
        .i_addr(i_addr), .i_wr_data(i_wr_data), .o_stall(o_stall), .o_done(o_done),
        .o_rd_data(o_rd_data), .o_misaligned(o_misaligned), .o_bus_err(o_bus_err),
        .m_axi_awaddr(awaddr), .m_axi_awprot(awprot), .m_axi_awvalid(awvalid),
        .m_axi_awready(awready), .m_axi_wdata(wdata), .m_axi_wstrb(wstrb),
        .m_axi_wvalid(wvalid), .m_axi_wready(wready), .m_axi_bresp(bresp),
        .m_axi_bvalid(bvalid), .m_axi_bready(bready), .m_axi_araddr(araddr),
        .m_axi_arprot(arprot), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
        .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rvalid(rvalid),
        .m_axi_rready(rready)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] load_model(input logic [63:0] word, input logic [2:0] width,
                                               input logic [2:0] off);
        int          nb;
        logic [63:0] mask;
        logic [63:0] v;
        nb   = 1 << width[1:0];
        mask = (nb == 8) ? '1 : ((64'd1 << (8 * nb)) - 64'd1);
        v    = (word >> (8 * int'(off))) & mask;
        if (width[2] && v[8 * nb - 1]) v = v | ~mask;
        return v;
    endfunction

    function automatic logic [7:0] strb_model(input logic [2:0] width, input logic [2:0] off);
        logic [15:0] s;
        s = ((16'd1 << (1 << width[1:0])) - 16'd1) << off;
        return s[7:0];
    endfunction

    task automatic slave_idle();
        awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0;
        bresp = 0; rresp = 0; rdata = '0;
    endtask

    // One access from request to completion; slave readies follow the given delays.
    task automatic access(input bit wr, input logic [2:0] width, input logic [63:0] addr,
                          input logic [63:0] wd, input logic [63:0] rword,
                          input logic [1:0] resp, input int aw_d, input int w_d,
                          input int b_d, input int ar_d, input int r_d);
        int nb, exp_done, c, stall_n, done_c, done_n, mis_c, mis_n;
        int awv_n, wv_n, arv_n, bw_n, rw_n, aw_hs, w_hs, b_hs, ar_hs, r_hs;
        bit mis;
        logic [31:0] got_awaddr, got_araddr;
        logic [63:0] got_wdata, got_rd, exp_rd;
        logic [7:0]  got_wstrb;
        logic        got_err;
        nb  = 1 << width[1:0];
        mis = (addr % 64'(nb)) != 0;
        {stall_n, done_n, mis_n, awv_n, wv_n, arv_n, bw_n, rw_n} = '0;
        {aw_hs, w_hs, b_hs, ar_hs, r_hs} = '0;
        done_c = -1; mis_c = -1;
        got_awaddr = '0; got_araddr = '0; got_wdata = '0; got_wstrb = '0;
        got_rd = '0; got_err = 1'b0;
        slave_idle();
        i_read = !wr; i_write = wr; i_width = width; i_addr = addr; i_wr_data = wd;
        #1;
        for (int k = 0; k < 60; k++) begin
            c = k;
            if (o_stall) stall_n++;
            if (o_misaligned) begin mis_n++; if (mis_c < 0) mis_c = c; end
            if (o_done) begin
                done_n++;
                if (done_c < 0) begin done_c = c; got_err = o_bus_err; got_rd = o_rd_data; end
            end
            if (awvalid) awv_n++;
            if (wvalid)  wv_n++;
            if (arvalid) arv_n++;
            if (bready)  bw_n++;
            if (rready)  rw_n++;
            awready = awvalid && (awv_n > aw_d);
            wready  = wvalid && (wv_n > w_d);
            arready = arvalid && (arv_n > ar_d);
            bvalid  = bready && (bw_n > b_d);
            bresp   = bvalid ? resp : 2'b00;
            rvalid  = rready && (rw_n > r_d);
            rresp   = rvalid ? resp : 2'b00;
            rdata   = rvalid ? rword : '0;
            if (awvalid && awready) begin aw_hs++; got_awaddr = awaddr; end
            if (wvalid && wready) begin w_hs++; got_wdata = wdata; got_wstrb = wstrb; end
            if (arvalid && arready) begin ar_hs++; got_araddr = araddr; end
            if (bvalid) b_hs++;
            if (rvalid) r_hs++;
            @(posedge clk);
            #1;
            i_read = 0; i_write = 0;
            slave_idle();
            #1;
            if (done_c >= 0 && k >= done_c + 1) break;
            if (mis && k >= 4) break;
        end
        if (mis) begin
            check("mis_pulse_cycle", 64'(mis_c), 64'd1);
            check("mis_pulse_count", 64'(mis_n), 64'd1);
            check("mis_no_done", 64'(done_n), 64'd0);
            check("mis_no_bus", 64'(awv_n + wv_n + arv_n), 64'd0);
            check("mis_stall_cycles", 64'(stall_n), 64'd1);
        end else begin
            exp_done = wr ? 3 + ((aw_d > w_d) ? aw_d : w_d) + b_d : 3 + ar_d + r_d;
            check("done_cycle", 64'(done_c), 64'(exp_done));
            check("done_count", 64'(done_n), 64'd1);
            check("stall_cycles", 64'(stall_n), 64'(exp_done));
            check("no_misaligned", 64'(mis_n), 64'd0);
            check("bus_err", 64'(got_err), 64'(resp != 2'b00));
            if (wr) begin
                check("awaddr", 64'(got_awaddr), 64'(addr[31:0]));
                check("wstrb", 64'(got_wstrb), 64'(strb_model(width, addr[2:0])));
                check("wdata", got_wdata, wd << (8 * int'(addr[2:0])));
                check("aw_hs", 64'(aw_hs), 64'd1);
                check("w_hs", 64'(w_hs), 64'd1);
                check("b_hs", 64'(b_hs), 64'd1);
                check("awvalid_cycles", 64'(awv_n), 64'(aw_d + 1));
                check("wvalid_cycles", 64'(wv_n), 64'(w_d + 1));
                check("store_no_ar", 64'(arv_n), 64'd0);
                check("store_keeps_rd", got_rd, last_rd);
            end else begin
                exp_rd = load_model(rword, width, addr[2:0]);
                check("araddr", 64'(got_araddr), 64'(addr[31:0]));
                check("ar_hs", 64'(ar_hs), 64'd1);
                check("r_hs", 64'(r_hs), 64'd1);
                check("arvalid_cycles", 64'(arv_n), 64'(ar_d + 1));
                check("load_no_aw", 64'(awv_n + wv_n), 64'd0);
                check("load_data", got_rd, exp_rd);
                last_rd = exp_rd;
            end
            check("rd_data_held", o_rd_data, last_rd);
        end
    endtask

    initial begin
        logic [2:0]  w;
        logic [63:0] a;
        int          nb;
        bit          found;
        rst = 1; i_read = 0; i_write = 0; i_width = 0; i_addr = '0; i_wr_data = '0;
        slave_idle();
        repeat (2) @(posedge clk);
        #1;
        check("reset_valids", 64'({awvalid, wvalid, bready, arvalid, rready}), 64'd0);
        check("reset_flags", 64'({o_stall, o_done, o_misaligned, o_bus_err}), 64'd0);
        check("reset_rd_data", o_rd_data, 64'd0);
        check("prot_tied", 64'({awprot, arprot}), 64'd0);
        rst = 0;
        @(posedge clk);
        #1;

        access(1, 3'b010, 64'h1004, 64'h0000_0000_DEAD_BEEF, '0, 2'b00, 0, 0, 0, 0, 0);
        access(0, 3'b100, 64'h2003, '0, 64'h0000_0000_8000_0000, 2'b00, 0, 0, 0, 0, 0);
        check("signed_byte_const", last_rd, 64'hFFFF_FFFF_FFFF_FF80);
        access(0, 3'b000, 64'h2003, '0, 64'h0000_0000_8000_0000, 2'b00, 0, 0, 0, 0, 0);
        check("unsigned_byte_const", last_rd, 64'h0000_0000_0000_0080);
        access(0, 3'b011, 64'h3008, '0, 64'h0123_4567_89AB_CDEF, 2'b10, 0, 0, 0, 4, 2);
        access(1, 3'b001, 64'h4006, 64'h1234_5678_9ABC_BEEF, '0, 2'b00, 3, 0, 1, 0, 0);
        access(0, 3'b010, 64'h1002, '0, '0, 2'b00, 0, 0, 0, 0, 0);

        // Reset while waiting for the write response.
        slave_idle();
        i_write = 1; i_width = 3'b011; i_addr = 64'h5000; i_wr_data = 64'h55;
        found = 0;
        for (int k = 0; k < 20 && !found; k++) begin
            awready = awvalid; wready = wvalid;
            @(posedge clk);
            #1;
            i_write = 0;
            slave_idle();
            #1;
            found = bready;
        end
        check("reached_wb", 64'(found), 64'd1);
        rst = 1;
        @(posedge clk);
        #1;
        check("mid_reset_valids", 64'({awvalid, wvalid, bready, arvalid, rready}), 64'd0);
        check("mid_reset_stall", 64'({o_stall, o_done}), 64'd0);
        rst = 0;
        last_rd = '0;
        @(posedge clk);
        #1;
        access(0, 3'b110, 64'h6004, '0, 64'h8765_4321_0000_0000, 2'b00, 0, 0, 0, 1, 1);

        for (int n = 0; n < 40; n++) begin
            w  = 3'($urandom_range(0, 7));
            nb = 1 << w[1:0];
            a  = {32'($urandom), 32'($urandom)};
            if ($urandom_range(0, 4) != 0) a = a & ~64'(nb - 1);
            access(1'($urandom_range(0, 1)), w, a, {32'($urandom), 32'($urandom)},
                   {32'($urandom), 32'($urandom)},
                   ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00,
                   int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                   int'($urandom_range(0, 2)), int'($urandom_range(0, 3)),
                   int'($urandom_range(0, 2)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
